// File: rtl/buffer_pkg.sv
// Shared sizing helpers and the per-cycle operation encoding for the buffer FIFO.
package buffer_pkg;

  // Pointer width. It never drops below one bit, so a single-entry buffer still has a real pointer signal.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // The occupancy count has to represent the values 0 through depth, inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_BOTH  = 2'b11
  } op_e;

endpackage

// File: rtl/buffer_mem.sv
// DEPTH x DATA_WIDTH register array with a synchronous write port and an asynchronous read port.
module buffer_mem
  import buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 1,
  localparam int ADDR_W    = ptr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_W-1:0]     raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  if (DEPTH == 1) begin : g_single
    logic [DATA_WIDTH-1:0] word_q;

    // NOTE: storage has no reset. The pointers and count define which words are valid, so stale contents are never observed.
    always_ff @(posedge clk) begin
      if (we_i) word_q <= wdata_i;
    end

    assign rdata_o = word_q;

    logic unused_addr;
    assign unused_addr = ^{waddr_i, raddr_i};
  end else begin : g_array
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
  end

endmodule

// File: rtl/buffer.sv
// Synchronous single-clock FIFO. Reads are registered, and full/empty are decoded from the occupancy count.
module buffer
  import buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = count_width(DEPTH);

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  wr_accept, rd_accept;
  op_e                   op;

  function automatic logic [PTR_W-1:0] advance(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // A write to a full buffer is still accepted when a read frees a slot on the same edge.
  assign rd_accept = rd_en && !empty;
  assign wr_accept = wr_en && (!full || rd_accept);
  assign op        = op_e'({rd_accept, wr_accept});

  buffer_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_mem (
    .clk    (clk),
    .we_i   (wr_accept),
    .waddr_i(wr_ptr_q),
    .wdata_i(data_in),
    .raddr_i(rd_ptr_q),
    .rdata_o(rd_word)
  );

  // NOTE: every next-state signal receives a default before any branch, so no path through this block can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    data_d   = data_q;
    if (wr_accept) wr_ptr_d = advance(wr_ptr_q);
    if (rd_accept) begin
      rd_ptr_d = advance(rd_ptr_q);
      data_d   = rd_word;
    end
    unique case (op)
      OP_WRITE: count_d = count_q + CNT_W'(1);
      OP_READ:  count_d = count_q - CNT_W'(1);
      default:  count_d = count_q;
    endcase
  end

  // NOTE: sequential state is updated only with non-blocking assignments, so every register samples values from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
    end
  end

  assign data_out = data_q;

endmodule

// File: tb/tb_buffer.sv
// Self-checking bench for buffer. One instance has a single entry and the other has four; both receive the same stimulus.
module tb_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [63:0] data_in = '0;
  logic [63:0] d1_dout, d4_dout;
  logic        d1_full, d1_empty, d4_full, d4_empty;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  buffer #(.DATA_WIDTH(64), .DEPTH(1)) u_d1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in),
    .data_out(d1_dout), .full(d1_full), .empty(d1_empty)
  );

  buffer #(.DATA_WIDTH(64), .DEPTH(4)) u_d4 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in),
    .data_out(d4_dout), .full(d4_full), .empty(d4_empty)
  );

  // Behavioural reference: a queue of stored words and the last word read, kept for each depth.
  logic [63:0] mq [2][$];
  logic [63:0] m_dout [2];
  int          m_depth [2] = '{1, 4};

  task automatic model_edge(input logic r, input logic w, input logic rd, input logic [63:0] din);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        mq[k].delete();
        m_dout[k] = '0;
      end else begin
        bit rd_ok, wr_ok;
        rd_ok = rd && (mq[k].size() > 0);
        wr_ok = w && ((mq[k].size() < m_depth[k]) || rd_ok);
        if (rd_ok) m_dout[k] = mq[k].pop_front();
        if (wr_ok) mq[k].push_back(din);
      end
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs are driven 1 time unit after the active clock edge, and outputs are sampled at that same point.
  task automatic cycle(input logic r, input logic w, input logic rd, input logic [63:0] din);
    rst = r; wr_en = w; rd_en = rd; data_in = din;
    @(posedge clk);
    model_edge(r, w, rd, din);
    #1;
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic check_d4(input string name, input logic [63:0] dout, input logic f, input logic e);
    check({name, ".d4_dout"}, d4_dout, dout);
    check({name, ".d4_full"}, 64'(d4_full), 64'(f));
    check({name, ".d4_empty"}, 64'(d4_empty), 64'(e));
  endtask

  typedef struct {
    logic        rst, wr, rd;
    logic [63:0] din;
    logic [63:0] exp_dout;
    logic        exp_full, exp_empty;
  } vec_t;

  vec_t vecs [15];

  initial begin
    // Directed table for the single-entry instance.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 64'h0,                  64'h0,                  1'b0, 1'b1};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 64'hA5A5A5A5A5A5A5A5,   64'h0,                  1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 64'h0,                  64'hA5A5A5A5A5A5A5A5,   1'b0, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 64'hDEADBEEFDEADBEEF,   64'hA5A5A5A5A5A5A5A5,   1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 64'h0,                  64'hDEADBEEFDEADBEEF,   1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 64'h1,                  64'hDEADBEEFDEADBEEF,   1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 64'h2,                  64'hDEADBEEFDEADBEEF,   1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 64'h0,                  64'h1,                  1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 64'h0,                  64'h1,                  1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 64'h1,                  64'h1,                  1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 64'h2,                  64'h1,                  1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 64'h0,                  64'h2,                  1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 64'h9,                  64'h2,                  1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 64'h0,                  64'h9,                  1'b0, 1'b1};
    vecs[14] = '{1'b1, 1'b1, 1'b0, 64'h5,                  64'h0,                  1'b0, 1'b1};

    for (int i = 0; i < 15; i++) begin
      cycle(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].din);
      check($sformatf("d1_vec%0d.dout", i), d1_dout, vecs[i].exp_dout);
      check($sformatf("d1_vec%0d.full", i), 64'(d1_full), 64'(vecs[i].exp_full));
      check($sformatf("d1_vec%0d.empty", i), 64'(d1_empty), 64'(vecs[i].exp_empty));
    end

    // Four-entry wrap-around.
    cycle(1'b1, 1'b0, 1'b0, 64'h0);
    check_d4("d4_reset", 64'h0, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) cycle(1'b0, 1'b1, 1'b0, 64'(i));
    check_d4("d4_fill", 64'h0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 64'h0);
    check_d4("d4_rd1", 64'h1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 64'h0);
    check_d4("d4_rd2", 64'h2, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 64'h5);
    cycle(1'b0, 1'b1, 1'b0, 64'h6);
    check_d4("d4_refill", 64'h2, 1'b1, 1'b0);
    for (int i = 3; i <= 6; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 64'h0);
      check(
        $sformatf("d4_drain%0d", i), d4_dout, 64'(i));
    end
    check_d4("d4_drained", 64'h6, 1'b0, 1'b1);

    // Reset in the middle of operation discards the stored words.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 64'(100 + i));
    cycle(1'b0, 1'b0, 1'b1, 64'h0);
    cycle(1'b1, 1'b0, 1'b0, 64'h0);
    check_d4("d4_midrst", 64'h0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 64'h7);
    cycle(1'b0, 1'b0, 1'b1, 64'h0);
    check_d4("d4_post_rst", 64'h7, 1'b0, 1'b1);

    // Randomised traffic, compared against the queue models. The read/write bias changes in phases so both the full and the empty boundaries are exercised.
    cycle(1'b1, 1'b0, 1'b0, 64'h0);
    for (int i = 0; i < 1200; i++) begin
      int wr_pct;
      logic r, w, rd;
      wr_pct = ((i / 150) % 2 == 0) ? 75 : 25;
      r  = ($urandom_range(0, 99) == 0);
      w  = ($urandom_range(0, 99) < wr_pct);
      rd = ($urandom_range(0, 99) >= wr_pct);
      if ($urandom_range(0, 9) == 0) begin
        w  = 1'b1;
        rd = 1'b1;
      end
      cycle(r, w, rd, {$urandom, $urandom});
      check("rnd.d1_dout", d1_dout, m_dout[0]);
      check("rnd.d1_full", 64'(d1_full), 64'(mq[0].size() == 1));
      check("rnd.d1_empty", 64'(d1_empty), 64'(mq[0].size() == 0));
      check("rnd.d4_dout", d4_dout, m_dout[1]);
      check("rnd.d4_full", 64'(d4_full), 64'(mq[1].size() == 4));
      check("rnd.d4_empty", 64'(d4_empty), 64'(mq[1].size() == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/buffer.md
Name: buffer

Overview:
- Synchronous single-clock FIFO buffer that stages DATA_WIDTH-bit words between a producer and a consumer.
- Default configuration is a one-entry, 64-bit holding register; DEPTH scales it to a circular FIFO.
- Reads are registered: data_out updates on the clock edge that accepts a read and holds otherwise.
- full and empty flags give the producer and consumer flow control.

Parameters:
- DATA_WIDTH, 64, width of each stored word and of data_in/data_out.
- DEPTH, 1, number of storage entries; legal range 1 or more, need not be a power of two.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  reset; synchronous, active-high.
- wr_en  input  1  write request; accepted at a rising edge when the write rule below permits.
- rd_en  input  1  read request; accepted at a rising edge when not empty.
- data_in  input  DATA_WIDTH  word written on an accepted write.
- data_out  output  DATA_WIDTH  registered read data; holds the last word read.
- full  output  1  high when the occupancy count equals DEPTH.
- empty  output  1  high when the occupancy count is 0.

Behaviour:
- State:
  - storage array of DEPTH words;
  - write pointer and read pointer, each max(1, clog2(DEPTH)) bits;
  - occupancy count, clog2(DEPTH+1) bits;
  - data_out register.
- Reset: while rst is high at a rising edge:
  - pointers = 0, count = 0, data_out = 0;
  - so empty = 1 and full = 0.
  - rst has priority over wr_en/rd_en in the same cycle.
  - Storage contents need not be cleared.
  - Reset asserted mid-operation discards all stored words at that edge.
- Write accepted when wr_en is high and either:
  - full is low, or
  - full is high and a read is accepted in the same cycle.
  - Effect: data_in is stored at the write pointer, and the pointer advances.
- Read accepted when rd_en is high and empty is low.
  - Effect: the word at the read pointer is loaded into data_out, and the pointer advances.
  - Read latency: data_out is valid immediately after the accepting edge.
- Pointer wrap: a pointer equal to DEPTH-1 wraps to 0 when it advances. With DEPTH=1 the pointers stay at 0.
- Count update:
  - +1 on write only;
  - -1 on read only;
  - unchanged when both a write and a read are accepted.
- full and empty are combinational decodes of the registered count. They are never both high.
- Write while full, with no accepted read: ignored. No state change, no error flag.
- Read while empty: ignored. data_out holds its value.
- Simultaneous wr_en and rd_en while empty: only the write occurs. There is no fall-through, so data_out keeps its old value.
- Simultaneous wr_en and rd_en while full (including DEPTH=1):
  - the read returns the oldest word;
  - the write stores the new word in the freed slot;
  - full stays 1.
- Simultaneous wr_en and rd_en otherwise: both occur; count is unchanged.
- No X propagation: data_out changes only on reset or an accepted read.

Decomposition:
- No shared package is needed. A clog2-style width helper (pointer and count widths) may live in the team's common constants package if one exists.
- One natural sub-module: buffer_mem, a DEPTH x DATA_WIDTH register array with a synchronous write port and an asynchronous read port.
- Pointer, count and flag logic stays in buffer.

Test Plan:
1. Reset with rst=1 for one edge, then rst=0 -> data_out=0, empty=1, full=0.
2. DEPTH=1 write-then-read:
   - write 0xA5A5A5A5A5A5A5A5 -> full=1, empty=0;
   - next read -> data_out=0xA5A5A5A5A5A5A5A5, empty=1, full=0;
   - then write 0xDEADBEEFDEADBEEF and read -> data_out=0xDEADBEEFDEADBEEF, empty=1.
3. DEPTH=1 overflow and underflow:
   - write 0x1, then write 0x2 while full -> ignored; a read returns 0x1;
   - a further read while empty -> data_out stays 0x1, empty=1.
4. DEPTH=1 simultaneous wr_en+rd_en while full holding 0x1, data_in=0x2 -> data_out=0x1, full stays 1; next read -> data_out=0x2.
5. DEPTH=4 wrap-around:
   - write 1,2,3,4 -> full=1;
   - read twice -> 1,2;
   - write 5,6 -> full=1;
   - read four times -> 3,4,5,6, then empty=1.
6. Reset mid-operation: DEPTH=4 holding 3 words, assert rst for one edge -> empty=1, data_out=0; a subsequent write 0x7 then read returns 0x7.
